// File: rtl/downmix_pkg.sv
// Shared types and derived-constant helpers for the downmix_decimator front end.
package downmix_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    function automatic int lo_half(input int sys_clk_freq, input int mixing_freq);
        return sys_clk_freq / (2 * mixing_freq);
    endfunction

    function automatic int decim_div(input int sys_clk_freq, input int out_rate);
        return sys_clk_freq / out_rate;
    endfunction

    // One sign-extension bit for the negated input plus enough headroom for a full window.
    function automatic int acc_width(input int data_width, input int decim);
        return data_width + 1 + clog2(decim);
    endfunction

endpackage

// File: rtl/downmix_lo_gen.sv
// Square-wave local oscillator: lo_sign toggles every LO_HALF cycles while clear is low.
module downmix_lo_gen
    import downmix_pkg::*;
#(
    parameter int LO_HALF = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic lo_sign
);

    localparam int CNT_W = (clog2(LO_HALF) > 0) ? clog2(LO_HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LO_HALF - 1);

    logic [CNT_W-1:0] lo_cnt_q, lo_cnt_d;
    logic             lo_sign_q, lo_sign_d;

    always_comb begin
        lo_cnt_d  = lo_cnt_q;
        lo_sign_d = lo_sign_q;
        if (clear) begin
            lo_cnt_d  = '0;
            lo_sign_d = 1'b0;
        end else if (lo_cnt_q == CNT_LAST) begin
            lo_cnt_d  = '0;
            lo_sign_d = ~lo_sign_q;
        end else begin
            lo_cnt_d = lo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lo_cnt_q  <= '0;
            lo_sign_q <= 1'b0;
        end else begin
            lo_cnt_q  <= lo_cnt_d;
            lo_sign_q <= lo_sign_d;
        end
    end

    assign lo_sign = lo_sign_q;

endmodule

// File: rtl/downmix_decimator.sv
// Square-wave downmixer with integrate-and-dump decimation.
// Optional feature: define DOWNMIX_SAT_EN to clamp the output and enable the sticky sat_flag.
module downmix_decimator
    import downmix_pkg::*;
#(
    parameter int SYS_CLK_FREQ = 6_400_000,
    parameter int MIXING_FREQ  = 320_000,
    parameter int OUT_RATE     = 16_000,
    parameter int DATA_WIDTH   = 16,
    parameter int SHIFT        = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] sample_in,
    output logic [DATA_WIDTH-1:0] sample_out,
    output logic                  sample_valid,
    output logic                  lo_sign,
    output logic                  sat_flag
);

    localparam int LO_HALF   = lo_half(SYS_CLK_FREQ, MIXING_FREQ);
    localparam int DECIM_DIV = decim_div(SYS_CLK_FREQ, OUT_RATE);
    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, DECIM_DIV);
    localparam int DCNT_W    = (clog2(DECIM_DIV) > 0) ? clog2(DECIM_DIV) : 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECIM_DIV - 1);

    state_t                        state_q, state_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic        [DCNT_W-1:0]      decim_cnt_q, decim_cnt_d;
    logic                          dump_q, dump_d;
    logic        [DATA_WIDTH-1:0]  pending_q, pending_d;
    logic        [DATA_WIDTH-1:0]  sample_out_q, sample_out_d;
    logic                          sample_valid_q, sample_valid_d;

    logic signed [DATA_WIDTH:0]    sample_ext;
    logic signed [DATA_WIDTH:0]    prod;
    logic signed [ACC_WIDTH-1:0]   prod_ext;
    logic signed [ACC_WIDTH-1:0]   sum;
    logic                          lo_clear;
    logic                          clamp_hit;

    // The LO only advances on RUN cycles that stay in RUN, so it enters every run at phase zero.
    assign lo_clear = !((state_q == RUN) && start);

    downmix_lo_gen #(
        .LO_HALF (LO_HALF)
    ) u_lo_gen (
        .clk     (clk),
        .rst     (rst),
        .clear   (lo_clear),
        .lo_sign (lo_sign)
    );

    assign sample_ext = {sample_in[DATA_WIDTH-1], sample_in};
    assign prod       = lo_sign ? -sample_ext : sample_ext;
    assign prod_ext   = {{(ACC_WIDTH-DATA_WIDTH-1){prod[DATA_WIDTH]}}, prod};
    assign sum        = acc_q + prod_ext;

`ifdef DOWNMIX_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] scaled;
    logic                        sat_q, sat_d;

    always_comb begin
        scaled    = sum >>> SHIFT;
        clamp_hit = 1'b0;
        pending_d = scaled[DATA_WIDTH-1:0];
        if (scaled > OUT_MAX) begin
            pending_d = OUT_MAX[DATA_WIDTH-1:0];
            clamp_hit = 1'b1;
        end else if (scaled < OUT_MIN) begin
            pending_d = OUT_MIN[DATA_WIDTH-1:0];
            clamp_hit = 1'b1;
        end
    end

    always_comb begin
        sat_d = sat_q | (dump_d & clamp_hit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_flag = sat_q;
`else
    always_comb begin
        clamp_hit = 1'b0;
        pending_d = DATA_WIDTH'(sum >>> SHIFT);
    end

    assign sat_flag = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        decim_cnt_d = decim_cnt_q;
        dump_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    acc_d       = '0;
                    decim_cnt_d = '0;
                end
            end
            RUN: begin
                // Dropping start discards the partial window, even on the dump cycle.
                if (!start) begin
                    state_d     = IDLE;
                    acc_d       = '0;
                    decim_cnt_d = '0;
                end else if (decim_cnt_q == DCNT_LAST) begin
                    dump_d      = 1'b1;
                    acc_d       = '0;
                    decim_cnt_d = '0;
                end else begin
                    acc_d       = sum;
                    decim_cnt_d = decim_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The reduced dump result is staged one cycle before it reaches the output register.
    always_comb begin
        sample_out_d   = dump_q ? pending_q : sample_out_q;
        sample_valid_d = dump_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            decim_cnt_q    <= '0;
            dump_q         <= 1'b0;
            pending_q      <= '0;
            sample_out_q   <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            decim_cnt_q    <= decim_cnt_d;
            dump_q         <= dump_d;
            pending_q      <= dump_d ? pending_d : pending_q;
            sample_out_q   <= sample_out_d;
            sample_valid_q <= sample_valid_d;
        end
    end

    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_downmix_decimator.sv
// Directed self-checking bench for downmix_decimator at SHIFT=9 and SHIFT=8.
// Expected SHIFT=8 overflow values depend on whether DOWNMIX_SAT_EN is defined.
module tb_downmix_decimator;

    localparam int MODE_DC   = 0;
    localparam int MODE_IN   = 1;
    localparam int MODE_ANTI = 2;

`ifdef DOWNMIX_SAT_EN
    localparam int EXP_S8_BIG = 32767;
    localparam int EXP_S8_SAT = 1;
`else
    localparam int EXP_S8_BIG = -14338;
    localparam int EXP_S8_SAT = 0;
`endif

    logic               clk;
    logic               rst;
    logic               start;
    logic signed [15:0] sample_in;
    logic        [15:0] sample_out;
    logic               sample_valid;
    logic               lo_sign;
    logic               sat_flag;
    logic        [15:0] sample_out_s8;
    logic               sample_valid_s8;
    logic               lo_sign_s8;
    logic               sat_flag_s8;

    int                 mode;
    logic signed [15:0] amp;
    int                 checks;
    int                 failures;
    int                 steps;
    int                 pulses;

    downmix_decimator dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .sample_in    (sample_in),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .lo_sign      (lo_sign),
        .sat_flag     (sat_flag)
    );

    downmix_decimator #(
        .SHIFT (8)
    ) dut_s8 (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .sample_in    (sample_in),
        .sample_out   (sample_out_s8),
        .sample_valid (sample_valid_s8),
        .lo_sign      (lo_sign_s8),
        .sat_flag     (sat_flag_s8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Phase-locked stimulus follows the LO of the SHIFT=9 instance; both LOs run in lockstep.
    assign sample_in = (mode == MODE_DC) ? amp
                     : ((lo_sign ^ (mode == MODE_ANTI)) ? -amp : amp);

    task automatic checkOutput(input string tag, input logic signed [63:0] actual,
                               input logic signed [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int new_mode, input int new_amp);
        mode = new_mode;
        amp  = 16'(new_amp);
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic waitValid(input string tag, input int budget, output int n);
        n = 0;
        do begin
            stepEdge();
            n++;
        end while (!sample_valid && n < budget);
        checkOutput(tag, sample_valid, 1);
    endtask

    task automatic countValid(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            stepEdge();
            if (sample_valid) cnt++;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        applyStimulus(MODE_DC, 1000);

        repeat (3) stepEdge();
        checkOutput("rst_sample_out", $signed(sample_out), 0);
        checkOutput("rst_sample_valid", sample_valid, 0);
        checkOutput("rst_lo_sign", lo_sign, 0);
        checkOutput("rst_sat_flag", sat_flag_s8, 0);
        rst = 1'b0;
        stepEdge();

        // DC input: LO phase, first pulse at edge 401, then every 400 cycles, all zero.
        start = 1'b1;
        repeat (10) stepEdge();
        checkOutput("lo_first_half", lo_sign, 0);
        stepEdge();
        checkOutput("lo_toggle", lo_sign, 1);
        repeat (10) stepEdge();
        checkOutput("lo_second_toggle", lo_sign, 0);
        waitValid("dc_valid_seen", 1000, steps);
        checkOutput("dc_first_valid_edge", steps + 21 - 1, 401);
        checkOutput("dc_out_first", $signed(sample_out), 0);
        stepEdge();
        checkOutput("valid_one_cycle", sample_valid, 0);
        waitValid("dc_valid2_seen", 1000, steps);
        checkOutput("dc_period", steps + 1, 400);
        checkOutput("dc_out_second", $signed(sample_out), 0);

        // In-phase and antiphase +/-1000; the first window after a switch is mixed and skipped.
        applyStimulus(MODE_IN, 1000);
        waitValid("in_skip_seen", 1000, steps);
        checkOutput("in_period", steps, 400);
        waitValid("in_valid_seen", 1000, steps);
        checkOutput("in_out_shift9", $signed(sample_out), 781);
        checkOutput("in_out_shift8", $signed(sample_out_s8), 1562);

        applyStimulus(MODE_ANTI, 1000);
        waitValid("anti_skip_seen", 1000, steps);
        waitValid("anti_valid_seen", 1000, steps);
        checkOutput("anti_out_shift9", $signed(sample_out), -782);
        checkOutput("anti_out_shift8", $signed(sample_out_s8), -1563);

        // Full-scale in-phase: SHIFT=8 overflows, SHIFT=9 fits.
        applyStimulus(MODE_IN, 32767);
        waitValid("big_skip_seen", 1000, steps);
        waitValid("big_valid_seen", 1000, steps);
        checkOutput("big_out_shift9", $signed(sample_out), 25599);
        checkOutput("big_sat_shift9", sat_flag, 0);
        checkOutput("big_out_shift8", $signed(sample_out_s8), EXP_S8_BIG);
        checkOutput("big_sat_shift8", sat_flag_s8, EXP_S8_SAT);

        // Abort at RUN cycle 200, idle 50 cycles, restart.
        countValid(199, pulses);
        start = 1'b0;
        countValid(50, pulses);
        checkOutput("abort_no_valid", pulses, 0);
        checkOutput("abort_hold", $signed(sample_out), 25599);
        start = 1'b1;
        waitValid("restart_valid_seen", 1000, steps);
        checkOutput("restart_latency", steps - 1, 401);
        checkOutput("restart_out", $signed(sample_out), 25599);

        // Mid-window reset with start held high.
        countValid(100, pulses);
        rst = 1'b1;
        stepEdge();
        checkOutput("midrst_sample_out", $signed(sample_out), 0);
        checkOutput("midrst_sample_valid", sample_valid, 0);
        checkOutput("midrst_lo_sign", lo_sign, 0);
        checkOutput("midrst_out_s8", $signed(sample_out_s8), 0);
        checkOutput("midrst_sat_s8", sat_flag_s8, 0);
        rst = 1'b0;
        waitValid("postrst_valid_seen", 1000, steps);
        checkOutput("postrst_latency", steps - 1, 401);
        checkOutput("postrst_out", $signed(sample_out), 25599);
        checkOutput("postrst_out_s8", $signed(sample_out_s8), EXP_S8_BIG);

        // start falls on the dump edge of a window whose dump would read -716.
        applyStimulus(MODE_ANTI, 1000);
        countValid(398, pulses);
        checkOutput("predump_no_valid", pulses, 0);
        start = 1'b0;
        countValid(5, pulses);
        checkOutput("dumpdrop_no_valid", pulses, 0);
        checkOutput("dumpdrop_hold", $signed(sample_out), 25599);
        checkOutput("dumpdrop_hold_s8", $signed(sample_out_s8), EXP_S8_BIG);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
